// File: rtl/rpn_ascii_parser.sv
// ASCII front-end for the RPN stack calculator: parses decimal operands and
// operators, issues one-cycle apply commands, returns the result and drains the stack.
module rpn_ascii_parser #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DRAIN_MAX = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       char_in,
    input  logic             char_valid,
    output logic             char_ready,
    output logic [WIDTH-1:0] calc_in,
    output logic [2:0]       calc_op,
    output logic             calc_apply,
    input  logic [WIDTH-1:0] calc_tail,
    input  logic             calc_valid,
    input  logic             calc_empty,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             error
);

    localparam int unsigned AW = WIDTH + 4;
    localparam int unsigned CW = $clog2(DRAIN_MAX + 1);
    localparam logic [AW-1:0] ACC_MAX = {4'b0000, {WIDTH{1'b1}}};

    localparam logic [2:0] OP_PUSH = 3'd0;
    localparam logic [2:0] OP_POP  = 3'd1;

    typedef enum logic [3:0] {
        S_IDLE, S_NUM, S_PUSH, S_OPER, S_CHECK, S_RESULT, S_DRAIN, S_DCHECK, S_ERR
    } state_t;

    // What follows the CHECK of the command currently in flight
    typedef enum logic [1:0] {P_IDLE, P_OPER, P_RESULT} pend_t;

    state_t           r_state, w_state_nxt;
    pend_t            r_pend, w_pend_nxt;
    logic [AW-1:0]    r_acc, w_acc_nxt;
    logic [2:0]       r_op, w_op_nxt;
    logic [CW-1:0]    r_pop_cnt, w_pop_cnt_nxt;
    logic             r_calc_apply, w_calc_apply_nxt;
    logic [2:0]       r_calc_op, w_calc_op_nxt;
    logic [WIDTH-1:0] r_calc_in, w_calc_in_nxt;
    logic [WIDTH-1:0] r_result, w_result_nxt;
    logic             r_result_valid, w_result_valid_nxt;
    logic             r_error, w_error_nxt;
    logic             r_char_ready, w_char_ready_nxt;

    logic             w_is_digit;
    logic             w_is_op;
    logic [2:0]       w_op_code;
    logic [AW-1:0]    w_acc_mac;
    logic             w_acc_ovf;

    assign w_is_digit = (char_in >= 8'h30) && (char_in <= 8'h39);
    assign w_acc_mac  = (r_acc * AW'(10)) + AW'(char_in - 8'h30);
    assign w_acc_ovf  = (w_acc_mac > ACC_MAX);

    // Operator byte decode
    always_comb begin
        w_is_op   = 1'b1;
        w_op_code = 3'd0;
        case (char_in)
            8'h2B:   w_op_code = 3'd2;
            8'h2A:   w_op_code = 3'd3;
            8'h2D:   w_op_code = 3'd4;
            8'h2F:   w_op_code = 3'd5;
            8'h25:   w_op_code = 3'd6;
            default: w_is_op   = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_pend         <= P_IDLE;
            r_acc          <= '0;
            r_op           <= '0;
            r_pop_cnt      <= '0;
            r_calc_apply   <= 1'b0;
            r_calc_op      <= '0;
            r_calc_in      <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_error        <= 1'b0;
            r_char_ready   <= 1'b1;
        end else begin
            r_state        <= w_state_nxt;
            r_pend         <= w_pend_nxt;
            r_acc          <= w_acc_nxt;
            r_op           <= w_op_nxt;
            r_pop_cnt      <= w_pop_cnt_nxt;
            r_calc_apply   <= w_calc_apply_nxt;
            r_calc_op      <= w_calc_op_nxt;
            r_calc_in      <= w_calc_in_nxt;
            r_result       <= w_result_nxt;
            r_result_valid <= w_result_valid_nxt;
            r_error        <= w_error_nxt;
            r_char_ready   <= w_char_ready_nxt;
        end
    end

    // Next state; command outputs are launched on the edge entering PUSH/OPER/DRAIN
    always_comb begin
        w_state_nxt        = r_state;
        w_pend_nxt         = r_pend;
        w_acc_nxt          = r_acc;
        w_op_nxt           = r_op;
        w_pop_cnt_nxt      = r_pop_cnt;
        w_calc_apply_nxt   = 1'b0;
        w_calc_op_nxt      = r_calc_op;
        w_calc_in_nxt      = r_calc_in;
        w_result_nxt       = r_result;
        w_result_valid_nxt = 1'b0;

        case (r_state)
            S_IDLE, S_NUM: begin
                if (char_valid) begin
                    if (w_is_digit) begin
                        if (w_acc_ovf) begin
                            w_state_nxt = S_ERR;
                        end else begin
                            w_acc_nxt   = w_acc_mac;
                            w_state_nxt = S_NUM;
                        end
                    end else if (char_in == 8'h20) begin
                        if (r_state == S_NUM) begin
                            w_state_nxt      = S_PUSH;
                            w_pend_nxt       = P_IDLE;
                            w_calc_apply_nxt = 1'b1;
                            w_calc_op_nxt    = OP_PUSH;
                            w_calc_in_nxt    = r_acc[WIDTH-1:0];
                            w_acc_nxt        = '0;
                        end
                    end else if (w_is_op) begin
                        w_op_nxt = w_op_code;
                        if (r_state == S_NUM) begin
                            w_state_nxt      = S_PUSH;
                            w_pend_nxt       = P_OPER;
                            w_calc_apply_nxt = 1'b1;
                            w_calc_op_nxt    = OP_PUSH;
                            w_calc_in_nxt    = r_acc[WIDTH-1:0];
                            w_acc_nxt        = '0;
                        end else begin
                            w_state_nxt      = S_OPER;
                            w_pend_nxt       = P_IDLE;
                            w_calc_apply_nxt = 1'b1;
                            w_calc_op_nxt    = w_op_code;
                        end
                    end else if (char_in == 8'h0A) begin
                        if (r_state == S_NUM) begin
                            w_state_nxt      = S_PUSH;
                            w_pend_nxt       = P_RESULT;
                            w_calc_apply_nxt = 1'b1;
                            w_calc_op_nxt    = OP_PUSH;
                            w_calc_in_nxt    = r_acc[WIDTH-1:0];
                            w_acc_nxt        = '0;
                        end else begin
                            w_state_nxt = S_RESULT;
                        end
                    end else begin
                        w_state_nxt = S_ERR;
                    end
                end
            end
            S_PUSH, S_OPER: w_state_nxt = S_CHECK;
            S_CHECK: begin
                if (!calc_valid) begin
                    w_state_nxt = S_ERR;
                end else begin
                    case (r_pend)
                        P_OPER: begin
                            w_state_nxt      = S_OPER;
                            w_pend_nxt       = P_IDLE;
                            w_calc_apply_nxt = 1'b1;
                            w_calc_op_nxt    = r_op;
                        end
                        P_RESULT: w_state_nxt = S_RESULT;
                        default:  w_state_nxt = S_IDLE;
                    endcase
                end
            end
            S_RESULT: begin
                if (calc_empty) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_result_nxt       = calc_tail;
                    w_result_valid_nxt = 1'b1;
                    w_state_nxt        = S_DRAIN;
                    w_calc_apply_nxt   = 1'b1;
                    w_calc_op_nxt      = OP_POP;
                    w_pop_cnt_nxt      = CW'(1);
                end
            end
            // Pop already launched on entry, which was gated by calc_empty=0
            S_DRAIN: w_state_nxt = calc_empty ? S_IDLE : S_DCHECK;
            S_DCHECK: begin
                if (calc_empty) begin
                    w_state_nxt = S_IDLE;
                end else if (!calc_valid || (r_pop_cnt == CW'(DRAIN_MAX))) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_state_nxt      = S_DRAIN;
                    w_calc_apply_nxt = 1'b1;
                    w_calc_op_nxt    = OP_POP;
                    w_pop_cnt_nxt    = r_pop_cnt + CW'(1);
                end
            end
            S_ERR:   w_state_nxt = S_ERR;
            default: w_state_nxt = S_ERR;
        endcase

        w_error_nxt      = r_error || (w_state_nxt == S_ERR);
        w_char_ready_nxt = (w_state_nxt == S_IDLE) || (w_state_nxt == S_NUM) ||
                           (w_state_nxt == S_ERR);
    end

    assign char_ready   = r_char_ready;
    assign calc_in      = r_calc_in;
    assign calc_op      = r_calc_op;
    assign calc_apply   = r_calc_apply;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign error        = r_error;

endmodule

// File: tb/tb_rpn_ascii_parser.sv
// Bench for rpn_ascii_parser: behavioural RPN calculator model plus directed string vectors.
module tb_rpn_ascii_parser;

    logic       clk;
    logic       reset;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic [7:0] calc_in;
    logic [2:0] calc_op;
    logic       calc_apply;
    logic [7:0] calc_tail;
    logic       calc_valid;
    logic       calc_empty;
    logic [7:0] result;
    logic       result_valid;
    logic       error;

    rpn_ascii_parser #(.WIDTH(8), .DRAIN_MAX(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .char_in      (char_in),
        .char_valid   (char_valid),
        .char_ready   (char_ready),
        .calc_in      (calc_in),
        .calc_op      (calc_op),
        .calc_apply   (calc_apply),
        .calc_tail    (calc_tail),
        .calc_valid   (calc_valid),
        .calc_empty   (calc_empty),
        .result       (result),
        .result_valid (result_valid),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Calculator model: 16-deep stack, status of last command on calc_valid
    logic [7:0]  m_stk [16];
    int          m_sp;
    logic        m_valid;
    logic [10:0] m_log [$];
    int          n_apply;
    int          n_rv;
    int          n_b2b;
    logic        prev_apply;

    assign calc_tail  = (m_sp > 0) ? m_stk[m_sp-1] : 8'h00;
    assign calc_empty = (m_sp == 0);
    assign calc_valid = m_valid;

    initial begin
        m_sp = 0; m_valid = 1'b1; n_apply = 0; n_rv = 0; n_b2b = 0; prev_apply = 1'b0;
    end

    always @(posedge clk) begin : mdl
        logic [7:0] a, b, r;
        if (result_valid) n_rv = n_rv + 1;
        if (calc_apply && prev_apply) n_b2b = n_b2b + 1;
        prev_apply = calc_apply;
        if (reset) begin
            m_sp    <= 0;
            m_valid <= 1'b1;
        end else if (calc_apply) begin
            n_apply = n_apply + 1;
            m_log.push_back({calc_op, calc_in});
            a = (m_sp >= 2) ? m_stk[m_sp-2] : 8'h00;
            b = (m_sp >= 1) ? m_stk[m_sp-1] : 8'h00;
            r = 8'h00;
            case (calc_op)
                3'd0: if (m_sp < 16) begin
                          m_stk[m_sp] <= calc_in; m_sp <= m_sp + 1; m_valid <= 1'b1;
                      end else m_valid <= 1'b0;
                3'd1: if (m_sp > 0) begin m_sp <= m_sp - 1; m_valid <= 1'b1; end
                      else m_valid <= 1'b0;
                default: begin
                    if (m_sp < 2 || ((calc_op == 3'd5 || calc_op == 3'd6) && b == 8'h00)) begin
                        m_valid <= 1'b0;
                    end else begin
                        case (calc_op)
                            3'd2:    r = a + b;
                            3'd3:    r = a * b;
                            3'd4:    r = a - b;
                            3'd5:    r = a / b;
                            default: r = a % b;
                        endcase
                        m_stk[m_sp-2] <= r;
                        m_sp          <= m_sp - 1;
                        m_valid       <= 1'b1;
                    end
                end
            endcase
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk = n_chk + 1;
        if (act == exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Present a byte from a negedge and hold it until the parser takes it
    task automatic send(input byte c);
        int n;
        char_in    = c;
        char_valid = 1'b1;
        n = 0;
        while (!char_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!char_ready) chk("char_ready_wait", int'(char_ready), 1);
        @(posedge clk);
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int k = 0; k < s.len(); k++) send(s[k]);
        repeat (60) @(negedge clk);
    endtask

    typedef struct {
        string      s;
        bit         rst;
        bit         exp_err;
        int         exp_rv;
        logic [7:0] exp_res;
        int         exp_apply;
    } vec_t;

    vec_t vecs [14];

    initial begin
        string nm;
        int    a0, r0, l0;

        vecs[0]  = '{"4 4+\n",                1'b1, 1'b0, 1, 8'd8,   4};
        vecs[1]  = '{"86 7/\n",               1'b1, 1'b0, 1, 8'd12,  4};
        vecs[2]  = '{"86 7%\n",               1'b0, 1'b0, 1, 8'd2,   4};
        vecs[3]  = '{"300",                   1'b1, 1'b1, 0, 8'd0,   0};
        vecs[4]  = '{"86 0/",                 1'b1, 1'b1, 0, 8'd0,   3};
        vecs[5]  = '{"\n",                    1'b1, 1'b1, 0, 8'd0,   0};
        vecs[6]  = '{"4x",                    1'b1, 1'b1, 0, 8'd0,   0};
        vecs[7]  = '{"255\n",                 1'b1, 1'b0, 1, 8'd255, 2};
        vecs[8]  = '{"256",                   1'b1, 1'b1, 0, 8'd0,   0};
        vecs[9]  = '{"3 4 5*+\n",             1'b1, 1'b0, 1, 8'd23,  6};
        vecs[10] = '{"9 5-\n",                1'b1, 1'b0, 1, 8'd4,   4};
        vecs[11] = '{" 7 \n",                 1'b1, 1'b0, 1, 8'd7,   2};
        vecs[12] = '{"2 3\n",                 1'b1, 1'b0, 1, 8'd3,   4};
        vecs[13] = '{"1 1 1 1 1 1 1 1 1 1\n", 1'b1, 1'b1, 1, 8'd1,   18};

        reset = 1'b1; char_valid = 1'b0; char_in = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_calc_apply",   int'(calc_apply),   0);
        chk("rst_calc_op",      int'(calc_op),      0);
        chk("rst_calc_in",      int'(calc_in),      0);
        chk("rst_result",       int'(result),       0);
        chk("rst_result_valid", int'(result_valid), 0);
        chk("rst_error",        int'(error),        0);
        chk("rst_char_ready",   int'(char_ready),   1);

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].rst) do_reset();
            a0 = n_apply;
            r0 = n_rv;
            send_str(vecs[i].s);
            nm = $sformatf("v%0d", i);
            chk({nm, "_error"},      int'(error),      int'(vecs[i].exp_err));
            chk({nm, "_rv_cycles"},  n_rv - r0,        vecs[i].exp_rv);
            chk({nm, "_applies"},    n_apply - a0,     vecs[i].exp_apply);
            chk({nm, "_char_ready"}, int'(char_ready), 1);
            if (vecs[i].exp_rv > 0) chk({nm, "_result"}, int'(result), int'(vecs[i].exp_res));
            if (!vecs[i].exp_err)   chk({nm, "_stack_empty"}, int'(calc_empty), 1);
        end

        // Error is sticky until reset, and reset clears it
        do_reset();
        chk("err_cleared", int'(error), 0);

        // Accumulator must not survive a reset mid-number
        send_str("12");
        do_reset();
        a0 = n_apply;
        l0 = m_log.size();
        send_str("5\n");
        chk("acc_rst_result",  int'(result), 5);
        chk("acc_rst_applies", n_apply - a0, 2);
        if (m_log.size() > l0) chk("acc_rst_first_push", int'(m_log[l0]), int'({3'd0, 8'd5}));
        else                   chk("acc_rst_log_size", m_log.size() - l0, 2);
        chk("acc_rst_error", int'(error), 0);

        // Reset while a push command is in flight drops it
        do_reset();
        a0 = n_apply;
        send(8'h39);
        char_in = 8'h20; char_valid = 1'b1;
        @(posedge clk);
        #1 reset = 1'b1;
        char_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_drop_apply", int'(calc_apply), 0);
        repeat (5) @(negedge clk);
        chk("rst_drop_count", n_apply - a0, 0);
        chk("rst_drop_empty", int'(calc_empty), 1);

        chk("no_back_to_back_apply", n_b2b, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
